// File: rtl/ohseq_det_if.sv
// Bus bundle for the one-hot sequence detector: qualified serial input plus
// detector state/match/count observation.
interface ohseq_det_if #(
   parameter int unsigned LEN   = 4,
   parameter int unsigned CNT_W = 8
);
   logic             en;
   logic             din;
   logic             overlap;
   logic             clr_cnt;
   logic [LEN-1:0]   state_oh;
   logic             match;
   logic [CNT_W-1:0] match_cnt;
   logic             illegal;

   modport master (
      output en, din, overlap, clr_cnt,
      input  state_oh, match, match_cnt, illegal
   );

   modport slave (
      input  en, din, overlap, clr_cnt,
      output state_oh, match, match_cnt, illegal
   );
endinterface

// File: rtl/ohseq_det.sv
// Parametrised one-hot serial pattern detector with KMP fallback transitions,
// run-time overlap select and saturating match counter.
// Optional ONEHOT_CHECK_EN adds an illegal-state checker that recovers to S0.
module ohseq_det #(
   parameter int unsigned    LEN     = 4,
   parameter logic [LEN-1:0] PATTERN = 4'b1011,
   parameter int unsigned    CNT_W   = 8
) (
   input logic       clk,
   input logic       rst,
   ohseq_det_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Bit i of the pattern in arrival order (i = 0 is received first).
   function automatic logic pat_bit(input int unsigned i);
      logic [LEN-1:0] t;
      t = PATTERN >> (LEN - 1 - i);
      return t[0];
   endfunction

   // Longest pattern prefix (< LEN) that is a suffix of the first k pattern
   // bits followed by b; covers advance, KMP fallback and full-match border.
   function automatic int unsigned nxt_len(input int unsigned k, input logic b);
      int unsigned best;
      int unsigned pos;
      logic        ok;
      logic        sbit;
      best = 0;
      for (int unsigned l = 1; l < LEN; l++) begin
         if (l <= k + 1) begin
            ok = 1'b1;
            for (int unsigned i = 0; i < l; i++) begin
               pos  = k + 1 - l + i;
               sbit = (pos < k) ? pat_bit(pos) : b;
               if (sbit != pat_bit(i)) ok = 1'b0;
            end
            if (ok) best = l;
         end
      end
      return best;
   endfunction

   logic [LEN-1:0]   state_q, state_d;
   logic             match_q, match_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [LEN-1:0]   nxt_or;
   logic [LEN-1:0]   tgt_ov [LEN][2];
   logic [LEN-1:0]   tgt_no [LEN][2];

   // One AND term per (state, din) pair, routed to its precomputed target bit.
   for (genvar k = 0; k < LEN; k++) begin : g_state
      for (genvar b = 0; b < 2; b++) begin : g_bit
         localparam logic           B_BIT   = 1'(b);
         localparam bit             FULL    = (k == LEN - 1) && (B_BIT == PATTERN[0]);
         localparam logic [LEN-1:0] MASK_OV = LEN'(1) << nxt_len(k, B_BIT);
         localparam logic [LEN-1:0] MASK_NO = FULL ? LEN'(1) : MASK_OV;
         logic hit;
         assign hit          = state_q[k] & (bus.din == B_BIT);
         assign tgt_ov[k][b] = {LEN{hit}} & MASK_OV;
         assign tgt_no[k][b] = {LEN{hit}} & MASK_NO;
      end
   end

`ifdef ONEHOT_CHECK_EN
   logic illegal_c;
   logic illegal_q, illegal_d;
   assign illegal_c = (state_q == '0) || ((state_q & (state_q - LEN'(1))) != '0);
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= LEN'(1);
         match_q   <= 1'b0;
         cnt_q     <= '0;
`ifdef ONEHOT_CHECK_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         match_q   <= match_d;
         cnt_q     <= cnt_d;
`ifdef ONEHOT_CHECK_EN
         illegal_q <= illegal_d;
`endif
      end
   end

   // Next-state: per-bit OR of the routed AND terms.
   always_comb begin
      nxt_or = '0;
      for (int k = 0; k < int'(LEN); k++) begin
         for (int b = 0; b < 2; b++) begin
            nxt_or = nxt_or | (bus.overlap ? tgt_ov[k][b] : tgt_no[k][b]);
         end
      end
      state_d = bus.en ? nxt_or : state_q;
`ifdef ONEHOT_CHECK_EN
      if (illegal_c) state_d = LEN'(1);
`endif
   end

   // Registered outputs: match pulse, saturating counter, illegal pulse.
   always_comb begin
      match_d = bus.en & state_q[LEN-1] & (bus.din == PATTERN[0]);
      cnt_d   = cnt_q;
      if (bus.clr_cnt) begin
         cnt_d = '0;
      end else if (match_d && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
`ifdef ONEHOT_CHECK_EN
      illegal_d = 1'b0;
      if (illegal_c) begin
         illegal_d = 1'b1;
         match_d   = 1'b0;
         cnt_d     = cnt_q;
      end
`endif
   end

   assign bus.state_oh  = state_q;
   assign bus.match     = match_q;
   assign bus.match_cnt = cnt_q;
`ifdef ONEHOT_CHECK_EN
   assign bus.illegal   = illegal_q;
`else
   assign bus.illegal   = 1'b0;
`endif

endmodule
